regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Owns the 128x8 motor-control register file and shares its single access port between N_REQ requesters.
- Requester 0 is the SPI slave and has fixed priority. Requesters 1..N_REQ-1 (channel sequencer, homing sequencer, ...) are served round-robin.
- An aging counter guarantees that no background requester starves under continuous SPI traffic.
- After reset the block zero-fills the register file before granting any access.

Parameters:
- N_REQ, 3, number of requesters (2..8); index 0 is the priority port.
- MAX_WAIT, 15, cycles a requester 1..N_REQ-1 may wait with req high before it overrides requester 0.
- DEPTH, 128, register file depth; address width AW = 7.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester access request
- we  in  N_REQ  per-requester write enable (1 = write, 0 = read)
- addr  in  N_REQ*7  packed addresses; requester i uses bits [7i+6:7i]
- wdata  in  N_REQ*8  packed write data; requester i uses bits [8i+7:8i]
- gnt  out  N_REQ  one-hot grant, combinational
- rvalid  out  N_REQ  read-data-valid, one-hot, registered
- rdata  out  8  read data, shared by all requesters, registered
- init_done  out  1  high once the zero-fill has completed

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, init_done=0, round-robin pointer=1, all wait counters=0. The FSM enters CLEAR with clear_addr=0.
- FSM CLEAR:
  - Each cycle writes 0 to clear_addr and increments clear_addr.
  - At clear_addr==DEPTH-1 the FSM moves to RUN and init_done rises on the next cycle.
  - gnt is held at 0 throughout CLEAR; the fill takes exactly 128 cycles.
- FSM RUN: one access per cycle. A transfer occurs when req[i] && gnt[i].
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - It may drop req the cycle after gnt or keep it high for back-to-back accesses.
  - gnt depends only on the current req and on registered arbiter state; it never depends on rdata.
- Writes: the write happens on the grant cycle. A read granted on any later cycle returns the new value.
- Reads: rdata and rvalid[i] are asserted exactly 1 cycle after the grant, with rvalid high for exactly 1 cycle. rdata holds its value until the next read.
- Arbitration, evaluated each cycle:
  1. Starving set S = {i >= 1 : req[i] && wait[i] == MAX_WAIT}. If S is non-empty, grant the first member of S at or after the round-robin pointer.
  2. Otherwise, if req[0] is high, grant requester 0.
  3. Otherwise, grant the first i >= 1 with req[i] high, searching from the pointer with wrap to 1.
- Round-robin pointer: after a grant to i >= 1, pointer becomes i+1, wrapping N_REQ to 1. It is unchanged when requester 0 is granted.
- Wait counters, for each i >= 1:
  - Cleared when gnt[i] is high or req[i] is low.
  - Otherwise incremented, saturating at MAX_WAIT.
- Simultaneous requests: exactly one gnt bit is high per cycle; gnt is all-zero if no req is high.
- Reset mid-operation:
  - Reset in RUN drops any pending rvalid and restarts CLEAR at address 0.
  - Reset in CLEAR also restarts at address 0.
  - Register contents are rewritten to 0.
- Address width rule: addr is used as-is (7 bits, no bounds check). Address 127 is valid and wraps nothing.

Decomposition:
- Shared package dcmctrl_pkg:
  - REG_AW=7, REG_DW=8, REG_DEPTH=128.
  - Requester index constants: REQ_SPI=0, REQ_MC=1, REQ_HOME=2.
  - FSM state enum {CLEAR, RUN}.
- One natural sub-module: rr_prio_pick. It is purely combinational, takes a request mask and a pointer, and returns a one-hot grant with wrap. It is instantiated twice: once for the starving set and once for the normal set.
- The storage array and the FSM stay in the top module.

Test Plan:
- Reset, then idle: init_done low for 128 cycles then high; reading addresses 0, 64 and 127 returns 0x00 with rvalid exactly 1 cycle after gnt.
- Requester 1 writes 0x5A to addr 0x10, then requester 2 reads 0x10 on the next cycle: rdata=0x5A and rvalid[2]=1 one cycle after gnt[2]; rvalid[0] and rvalid[1] stay 0.
- req[0], req[1] and req[2] held high continuously: requester 0 granted every cycle except one forced grant to requester 1 after 15 waiting cycles, then one to requester 2. No requester 1..2 waits more than 16 cycles.
- req[1] and req[2] high, req[0] low, for 6 cycles: grants alternate 1,2,1,2,1,2 and the pointer wraps 2 -> 1.
- Assert reset for 1 cycle while requester 1 has a read granted: no rvalid on the following cycle, gnt=0 for 128 cycles, and previously written addr 0x10 reads back 0x00.
- Write 0xFF to addr 127 via requester 0 and read it back via requester 1: returns 0xFF, with no aliasing at addr 0.

Source files
------------

// File: rtl/dcmctrl_pkg.sv
// Shared definitions for the motor-control register file and its access arbiter.
package dcmctrl_pkg;

  localparam int REG_AW    = 7;
  localparam int REG_DW    = 8;
  localparam int REG_DEPTH = 128;

  localparam int REQ_SPI  = 0;
  localparam int REQ_MC   = 1;
  localparam int REQ_HOME = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_arbiter_rr_prio_pick.sv
// Combinational round-robin picker over requesters 1..N-1: first set mask bit
// at or after ptr, wrapping back to index 1. Bit 0 is never picked.
module rr_prio_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  logic found_s;
  logic hit_s;

  // Two passes: upper segment [ptr, N-1] first, then the wrapped segment from 1.
  always_comb begin
    pick    = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int j = 1; j < N; j++) begin
      hit_s   = ~found_s & mask[j] & (j >= int'(ptr));
      pick[j] = hit_s;
      found_s = found_s | hit_s;
    end
    for (int j = 1; j < N; j++) begin
      hit_s   = ~found_s & mask[j];
      pick[j] = pick[j] | hit_s;
      found_s = found_s | hit_s;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// 128x8 motor-control register file with a priority SPI port, round-robin
// background requesters, starvation aging and zero-fill after reset.
module regfile_arbiter
  import dcmctrl_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int MAX_WAIT = 15,
  parameter int DEPTH    = REG_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*REG_AW-1:0] addr,
  input  logic [N_REQ*REG_DW-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [REG_DW-1:0]       rdata,
  output logic                    init_done
);

  localparam int AW = REG_AW;
  localparam int DW = REG_DW;
  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(MAX_WAIT + 1);

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [AW-1:0]    clear_addr_r;
  logic             init_done_r;
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    ptr_nxt_s;
  logic [WW-1:0]    wait_r [N_REQ];
  logic [DW-1:0]    mem_r [DEPTH];
  logic [N_REQ-1:0] starve_mask_s;
  logic [N_REQ-1:0] norm_mask_s;
  logic [N_REQ-1:0] starve_pick_s;
  logic [N_REQ-1:0] norm_pick_s;
  logic [N_REQ-1:0] gnt_s;
  logic [N_REQ-1:0] rvalid_r;
  logic [DW-1:0]    rdata_r;
  logic [AW-1:0]    sel_addr_s;
  logic [DW-1:0]    sel_wdata_s;
  logic             sel_we_s;
  logic             xfer_s;

  // Candidate sets for the aging override and for plain round-robin.
  always_comb begin
    starve_mask_s = '0;
    norm_mask_s   = '0;
    for (int i = 1; i < N_REQ; i++) begin
      norm_mask_s[i]   = req[i];
      starve_mask_s[i] = req[i] & (wait_r[i] == WW'(MAX_WAIT));
    end
  end

  rr_prio_pick #(.N(N_REQ), .PW(PW)) u_pick_starve (
    .mask (starve_mask_s),
    .ptr  (ptr_r),
    .pick (starve_pick_s)
  );

  rr_prio_pick #(.N(N_REQ), .PW(PW)) u_pick_norm (
    .mask (norm_mask_s),
    .ptr  (ptr_r),
    .pick (norm_pick_s)
  );

  // Grant: starving background port, else SPI, else round-robin.
  always_comb begin
    gnt_s = '0;
    if (reset || (state_r != RUN)) begin
      gnt_s = '0;
    end else if (|starve_mask_s) begin
      gnt_s = starve_pick_s;
    end else if (req[REQ_SPI]) begin
      gnt_s[REQ_SPI] = 1'b1;
    end else begin
      gnt_s = norm_pick_s;
    end
  end

  // One-hot grant steers the granted requester's command onto the array port.
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_we_s    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_addr_s  = sel_addr_s  | (addr[i*AW +: AW]  & {AW{gnt_s[i]}});
      sel_wdata_s = sel_wdata_s | (wdata[i*DW +: DW] & {DW{gnt_s[i]}});
      sel_we_s    = sel_we_s    | (we[i] & gnt_s[i]);
    end
    xfer_s = |(req & gnt_s);
  end

  // Pointer moves past a served background requester; SPI grants leave it alone.
  always_comb begin
    ptr_nxt_s = ptr_r;
    for (int i = 1; i < N_REQ; i++) begin
      ptr_nxt_s = gnt_s[i] ? ((i == N_REQ - 1) ? PW'(1) : PW'(i + 1)) : ptr_nxt_s;
    end
  end

  // FSM next state: leave CLEAR after the last address has been zeroed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clear_addr_r == AW'(DEPTH - 1)) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = CLEAR;
    endcase
  end

  // FSM state, fill address and init_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= CLEAR;
      clear_addr_r <= '0;
      init_done_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      clear_addr_r <= (state_r == CLEAR) ? clear_addr_r + 1'b1 : clear_addr_r;
      init_done_r  <= (state_nxt_s == RUN);
    end
  end

  // Arbiter state and registered read return.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r    <= PW'(1);
      rvalid_r <= '0;
      rdata_r  <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        wait_r[i] <= '0;
      end
    end else begin
      ptr_r     <= ptr_nxt_s;
      rvalid_r  <= gnt_s & req & ~we;
      wait_r[0] <= '0;
      if (xfer_s && !sel_we_s) begin
        rdata_r <= mem_r[sel_addr_s];
      end
      for (int i = 1; i < N_REQ; i++) begin
        if (gnt_s[i] || !req[i]) begin
          wait_r[i] <= '0;
        end else if (wait_r[i] != WW'(MAX_WAIT)) begin
          wait_r[i] <= wait_r[i] + 1'b1;
        end
      end
    end
  end

  // Storage: zero-fill port during CLEAR, arbitrated writes during RUN.
  always_ff @(posedge clk) begin
    if (state_r == CLEAR) begin
      mem_r[clear_addr_r] <= '0;
    end else if (xfer_s && sel_we_s) begin
      mem_r[sel_addr_s] <= sel_wdata_s;
    end
  end

  assign gnt       = gnt_s;
  assign rvalid    = rvalid_r;
  assign rdata     = rdata_r;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: zero-fill, read/write, round-robin,
// aging override, mid-run reset and the top address.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [20:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [7:0]  rdata;
  logic        init_done;

  int vec  = 0;
  int errs = 0;

  regfile_arbiter #(.N_REQ(3), .MAX_WAIT(15), .DEPTH(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req   = 3'b000;
    we    = 3'b000;
    addr  = 21'd0;
    wdata = 24'd0;
  endtask

  task automatic drive(input int i, input logic w, input logic [6:0] a, input logic [7:0] d);
    req[i]         = 1'b1;
    we[i]          = w;
    addr[7*i +: 7] = a;
    wdata[8*i +: 8] = d;
  endtask

  task automatic test_reset();
    logic [6:0] rd_addrs [3];
    rd_addrs = '{7'd0, 7'd64, 7'd127};
    reset = 1'b1;
    idle();
    req[0] = 1'b1;
    tick();
    vec++;
    if (rvalid !== 3'b000 || rdata !== 8'h00 || init_done !== 1'b0) begin
      errs++;
      $display("FAIL reset_values: rvalid=%b rdata=%h init_done=%b, expected 000/00/0", rvalid, rdata, init_done);
    end
    reset = 1'b0;
    for (int k = 0; k < 128; k++) begin
      #1;
      vec++;
      if (gnt !== 3'b000 || init_done !== 1'b0) begin
        errs++;
        $display("FAIL clear_cycle_%0d: gnt=%b init_done=%b, expected 000/0", k, gnt, init_done);
      end
      tick();
    end
    vec++;
    if (init_done !== 1'b1) begin
      errs++;
      $display("FAIL init_done_rise: got %b expected 1", init_done);
    end
    for (int n = 0; n < 3; n++) begin
      drive(0, 1'b0, rd_addrs[n], 8'h00);
      #1;
      vec++;
      if (gnt !== 3'b001) begin
        errs++;
        $display("FAIL idle_read_gnt_%0d: gnt=%b expected 001", n, gnt);
      end
      tick();
      vec++;
      if (rvalid !== 3'b001 || rdata !== 8'h00) begin
        errs++;
        $display("FAIL idle_read_data_%0d: rvalid=%b rdata=%h expected 001/00", n, rvalid, rdata);
      end
    end
    idle();
    tick();
    vec++;
    if (rvalid !== 3'b000) begin
      errs++;
      $display("FAIL rvalid_one_cycle: rvalid=%b expected 000", rvalid);
    end
  endtask

  task automatic test_write_read();
    idle();
    drive(1, 1'b1, 7'h10, 8'h5A);
    #1;
    vec++;
    if (gnt !== 3'b010) begin
      errs++;
      $display("FAIL wr_gnt: gnt=%b expected 010", gnt);
    end
    tick();
    idle();
    drive(2, 1'b0, 7'h10, 8'h00);
    #1;
    vec++;
    if (gnt !== 3'b100 || rvalid !== 3'b000) begin
      errs++;
      $display("FAIL rd_gnt: gnt=%b rvalid=%b expected 100/000", gnt, rvalid);
    end
    tick();
    idle();
    #1;
    vec++;
    if (rvalid !== 3'b100 || rdata !== 8'h5A) begin
      errs++;
      $display("FAIL rd_data: rvalid=%b rdata=%h expected 100/5a", rvalid, rdata);
    end
    tick();
    vec++;
    if (rvalid !== 3'b000 || rdata !== 8'h5A) begin
      errs++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%h expected 000/5a", rvalid, rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [6];
    exp_g = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
    idle();
    drive(1, 1'b0, 7'h10, 8'h00);
    drive(2, 1'b0, 7'h10, 8'h00);
    for (int t = 0; t < 6; t++) begin
      #1;
      vec++;
      if (gnt !== exp_g[t]) begin
        errs++;
        $display("FAIL rr_gnt_%0d: gnt=%b expected %b", t, gnt, exp_g[t]);
      end
      if (t > 0) begin
        vec++;
        if (rvalid !== exp_g[t-1] || rdata !== 8'h5A) begin
          errs++;
          $display("FAIL rr_rvalid_%0d: rvalid=%b rdata=%h expected %b/5a", t, rvalid, rdata, exp_g[t-1]);
        end
      end
      tick();
    end
    idle();
    #1;
    vec++;
    if (rvalid !== 3'b100) begin
      errs++;
      $display("FAIL rr_last_rvalid: rvalid=%b expected 100", rvalid);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [2:0] exp_g;
    idle();
    drive(0, 1'b0, 7'h10, 8'h00);
    drive(1, 1'b0, 7'h10, 8'h00);
    drive(2, 1'b0, 7'h10, 8'h00);
    for (int t = 0; t < 20; t++) begin
      exp_g = (t < 15) ? 3'b001 : (t == 15) ? 3'b010 : (t == 16) ? 3'b100 : 3'b001;
      #1;
      vec++;
      if (gnt !== exp_g) begin
        errs++;
        $display("FAIL starve_gnt_%0d: gnt=%b expected %b", t, gnt, exp_g);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    drive(1, 1'b0, 7'h10, 8'h00);
    #1;
    vec++;
    if (gnt !== 3'b010) begin
      errs++;
      $display("FAIL mid_pre_gnt: gnt=%b expected 010", gnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    req[0] = 1'b1;
    vec++;
    if (rvalid !== 3'b000) begin
      errs++;
      $display("FAIL mid_rvalid_drop: rvalid=%b expected 000", rvalid);
    end
    for (int k = 0; k < 128; k++) begin
      #1;
      vec++;
      if (gnt !== 3'b000 || init_done !== 1'b0) begin
        errs++;
        $display("FAIL mid_clear_%0d: gnt=%b init_done=%b expected 000/0", k, gnt, init_done);
      end
      tick();
    end
    idle();
    drive(1, 1'b0, 7'h10, 8'h00);
    #1;
    vec++;
    if (gnt !== 3'b010 || init_done !== 1'b1) begin
      errs++;
      $display("FAIL mid_post_gnt: gnt=%b init_done=%b expected 010/1", gnt, init_done);
    end
    tick();
    idle();
    vec++;
    if (rvalid !== 3'b010 || rdata !== 8'h00) begin
      errs++;
      $display("FAIL mid_cleared_data: rvalid=%b rdata=%h expected 010/00", rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_addr_boundary();
    idle();
    drive(0, 1'b1, 7'd127, 8'hFF);
    #1;
    vec++;
    if (gnt !== 3'b001) begin
      errs++;
      $display("FAIL top_wr_gnt: gnt=%b expected 001", gnt);
    end
    tick();
    idle();
    drive(1, 1'b0, 7'd127, 8'h00);
    #1;
    vec++;
    if (gnt !== 3'b010) begin
      errs++;
      $display("FAIL top_rd_gnt: gnt=%b expected 010", gnt);
    end
    tick();
    idle();
    drive(2, 1'b0, 7'd0, 8'h00);
    #1;
    vec++;
    if (gnt !== 3'b100 || rvalid !== 3'b010 || rdata !== 8'hFF) begin
      errs++;
      $display("FAIL top_rd_data: gnt=%b rvalid=%b rdata=%h expected 100/010/ff", gnt, rvalid, rdata);
    end
    tick();
    idle();
    vec++;
    if (rvalid !== 3'b100 || rdata !== 8'h00) begin
      errs++;
      $display("FAIL addr0_alias: rvalid=%b rdata=%h expected 100/00", rvalid, rdata);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_round_robin();
    test_starvation();
    test_reset_mid();
    test_addr_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
